// File: rtl/sgdmac_read_engine.sv
// sgdmac_read_engine: AXI3 read master that splits a {src, bytes} command into
// 64-byte INCR bursts of 32-bit beats and pushes every beat into the data FIFO.
module sgdmac_read_engine #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic        start_i,
  input  logic [47:0] cmd_i,
  output logic        done_o,
  output logic        err_o,
  input  logic        fifo_full_i,
  output logic        fifo_wren_o,
  output logic [31:0] fifo_wdata_o
);
  localparam logic [1:0] IDLE = 2'd0, AR_REQ = 2'd1, R_DATA = 2'd2;
  logic [1:0]  r_state;
  logic [31:0] r_src_addr;
  logic [15:0] r_remaining;
  logic [3:0]  r_beat_cnt;
  logic        r_err;
  logic [15:0] w_eff;
  logic        w_big, w_ar_hs, w_accept, w_last, w_unused;
  assign w_eff = {cmd_i[15:2], 2'b00};
  assign w_big = r_remaining >= 16'd64;
  assign w_ar_hs = arvalid_o && arready_i;
  assign w_accept = rvalid_i && rready_o;
  assign w_last = r_beat_cnt == 4'd0;
  assign w_unused = ^{rid_i, rresp_i[0], FIFO_DEPTH > 0};
  assign arid_o = 4'd0;
  assign arsize_o = 3'b010;
  assign arburst_o = 2'b01;
  assign araddr_o = r_src_addr;
  // a zero remainder must report length 0 rather than the -1 underflow
  assign arlen_o = r_remaining == 16'd0 ? 4'd0 : w_big ? 4'hF : r_remaining[5:2] - 4'd1;
  assign arvalid_o = r_state == AR_REQ;
  assign rready_o = r_state == R_DATA && !fifo_full_i;
  assign done_o = r_state == IDLE;
  assign err_o = r_err;
  assign fifo_wren_o = w_accept;
  assign fifo_wdata_o = rdata_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_src_addr <= 32'd0;
      r_remaining <= 16'd0;
      r_beat_cnt <= 4'd0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_i && w_eff != 16'd0) begin
          r_src_addr <= cmd_i[47:16];
          r_remaining <= w_eff;
          r_err <= 1'b0;
          r_state <= AR_REQ;
        end
        AR_REQ: if (w_ar_hs) begin
          r_beat_cnt <= arlen_o;
          r_src_addr <= r_src_addr + 32'd64;
          r_remaining <= w_big ? r_remaining - 16'd64 : 16'd0;
          r_state <= R_DATA;
        end
        R_DATA: if (w_accept) begin
          r_beat_cnt <= r_beat_cnt - 4'd1;
          // burst length is owned by beat_cnt; a misplaced rlast only flags an error
          if (rresp_i[1] || (rlast_i != w_last)) r_err <= 1'b1;
          if (w_last) r_state <= r_remaining == 16'd0 ? IDLE : AR_REQ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sgdmac_read_engine.md
# sgdmac_read_engine

AXI3 read master stage of the scatter-gather DMA, sitting directly upstream of the data FIFO that the write engine drains. It accepts one {source address, byte count} command from the descriptor unit and splits it into 64-byte INCR bursts of 32-bit beats. It pushes every returned beat into the data FIFO, applying backpressure to the R channel whenever the FIFO is full. It reports idle status and a sticky error flag back to the descriptor unit.

## Interface
- `FIFO_DEPTH`, default 64: data FIFO depth in words, informational only; the block does not assume any headroom.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `arid_o`  out  4  constant 4'd0.
- `araddr_o`  out  32  burst start address.
- `arlen_o`  out  4  beats minus 1.
- `arsize_o`  out  3  constant 3'b010 (4 bytes).
- `arburst_o`  out  2  constant 2'b01 (INCR).
- `arvalid_o`  out  1  address request valid.
- `arready_i`  in  1  address accepted.
- `rid_i`  in  4  ignored.
- `rdata_i`  in  32  read data.
- `rresp_i`  in  2  read response.
- `rlast_i`  in  1  last beat of burst.
- `rvalid_i`  in  1  read data valid.
- `rready_o`  out  1  read data ready.
- `start_i`  in  1  command strobe; sampled only while idle.
- `cmd_i`  in  48  {src_addr[31:0], byte_count[15:0]}.
- `done_o`  out  1  high exactly while in IDLE.
- `err_o`  out  1  sticky error flag.
- `fifo_full_i`  in  1  data FIFO full.
- `fifo_wren_o`  out  1  FIFO push strobe.
- `fifo_wdata_o`  out  32  FIFO push data; equals `rdata_i`.

## Operation
- **Registers:**
  - `state`: IDLE, AR_REQ, R_DATA.
  - `src_addr[31:0]`.
  - `remaining[15:0]`, in bytes.
  - `beat_cnt[3:0]`.
  - `err`.
- **IDLE:** `done_o`=1 and `arvalid_o`=0.
  - On `start_i`, the effective count is {cmd_i[15:2], 2'b00}; `cmd_i[1:0]` is discarded.
  - If the effective count is 0, stay in IDLE. No bus activity occurs and `err` is unchanged.
  - Otherwise:
    - Load `src_addr` from `cmd_i[47:16]` and `remaining` from the effective count.
    - Clear `err`.
    - Go to AR_REQ.
- **AR_REQ:**
  - `arvalid_o`=1, `araddr_o`=`src_addr`.
  - `arlen_o` = 4'hF if `remaining` >= 64, else `remaining[5:2]`-1.
  - On `arready_i`:
    - Set `beat_cnt` to `arlen_o` and go to R_DATA.
    - Add 64 to `src_addr`, wrapping modulo 2^32.
    - If `remaining` >= 64, subtract 64 from `remaining`; otherwise set `remaining` to 0.
  - `arvalid_o` must remain high until `arready_i`; `araddr_o` and `arlen_o` stay stable while waiting.
- **R_DATA:**
  - `rready_o` = !`fifo_full_i`.
  - A beat is accepted when `rvalid_i` && `rready_o`. On acceptance:
    - `fifo_wren_o`=1 in the same cycle.
    - `beat_cnt` decrements.
    - If `rresp_i[1]`=1 (SLVERR or DECERR), set `err`. The data is still pushed and the transfer continues.
  - Burst end is governed by `beat_cnt`, not by `rlast_i`. The beat accepted with `beat_cnt`==0 is the last beat.
    - If `rlast_i` != (`beat_cnt`==0) on any accepted beat, set `err`.
    - After the last beat, go to IDLE if `remaining`==0, otherwise go to AR_REQ.
- Source addresses are 64-byte aligned by descriptor contract; the block performs no 4 KB boundary check.
- Only one burst is outstanding at a time.
- `arlen_o` is 0 whenever `remaining`==0.
- `err_o` = `err`; it is cleared only by reset or by an accepted non-zero command.
- `start_i` outside IDLE is ignored.

## Timing
- **Reset values:**
  - `state`=IDLE, so `done_o`=1.
  - `arvalid_o`=0, `rready_o`=0, `fifo_wren_o`=0.
  - `araddr_o`=0, `arlen_o`=0, `err_o`=0.
- **Start latency:** `start_i` in cycle N gives `arvalid_o`=1 and `done_o`=0 in cycle N+1.
- **AR to R_DATA:** the AR handshake in cycle M puts the block in R_DATA with `rready_o` valid in cycle M+1. Beats arriving earlier are not accepted.
- **Burst to burst:** the last beat in cycle K gives `arvalid_o`=1 in cycle K+1, or `done_o`=1 in K+1 if finished.
- **FIFO push:** combinational in the acceptance cycle, with no buffering. `fifo_full_i` high forces `rready_o` low in the same cycle.
- **Throughput:** 1 beat per cycle when `fifo_full_i`=0 and `rvalid_i`=1.
- **Reset mid-transfer:** the block returns to IDLE on the next edge and drops all valid and ready outputs. The interconnect is reset together with it.

## Test plan
- **Single short command:** cmd = {32'h1000_0000, 16'd16}, single-cycle `arready_i`. Expect one AR with addr 32'h1000_0000, `arlen_o`=3; 4 pushes with matching data; `done_o` back to 1 one cycle after the 4th beat; `err_o`=0.
- **Multi-burst command:** cmd = {32'h2000_0000, 16'd200} (50 words). Expect ARs at 32'h2000_0000/0040/0080/00C0 with `arlen_o`=F,F,F,1; 50 pushes total.
- **Backpressure:** hold `fifo_full_i`=1 for 5 cycles mid-burst while `rvalid_i`=1. Expect `rready_o`=0 and no pushes for those 5 cycles, then the stream resumes with no beat lost or duplicated.
- **Error response:** `rresp_i`=2'b10 on beat 2 of 4. Expect all 4 beats pushed, `err_o`=1 after the transfer, and `err_o` cleared by the next non-zero start.
- **Protocol check:** `rlast_i` asserted on beat 1 of a 4-beat burst. Expect `err_o`=1 and the engine still consuming exactly 4 beats.
- **Degenerate inputs:** `byte_count`=16'd3 leaves the block idle with no AR. `start_i` pulsed in R_DATA is ignored. Reset asserted mid-burst gives `done_o`=1 and `arvalid_o`=0 on the next cycle.
